// File: rtl/id_ex_register_pkg.sv
// Shared definitions for the ID/EX stage: ALU op encoding, default widths,
// and the values that make up a pipeline bubble.
package id_ex_register_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned REG_AW_DEF = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // A bubble is an all-zero slot that executes as an invalid ADD.
  localparam logic       BUBBLE_VALID = 1'b0;
  localparam logic [3:0] BUBBLE_ALUOP = ALU_ADD;

endpackage

// File: rtl/id_ex_register_if.sv
// Decode-to-execute bundle: id_* fields and pipeline controls in, registered
// idex_* fields, hazard flag and bubble counter out.
interface id_ex_register_if #(
  parameter int unsigned XLEN   = id_ex_register_pkg::XLEN_DEF,
  parameter int unsigned REG_AW = id_ex_register_pkg::REG_AW_DEF,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [3:0]        id_aluop;
  logic              id_alusrc;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_memtoreg;
  logic              id_branch;
  logic              stall;
  logic              flush;

  logic              idex_valid;
  logic [XLEN-1:0]   idex_pc;
  logic [XLEN-1:0]   idex_rs1_data;
  logic [XLEN-1:0]   idex_rs2_data;
  logic [XLEN-1:0]   idex_imm;
  logic [REG_AW-1:0] idex_rs1;
  logic [REG_AW-1:0] idex_rs2;
  logic [REG_AW-1:0] idex_rd;
  logic [3:0]        idex_aluop;
  logic              idex_alusrc;
  logic              idex_regwrite;
  logic              idex_memread;
  logic              idex_memwrite;
  logic              idex_memtoreg;
  logic              idex_branch;
  logic              load_use_hazard;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite,
           id_memtoreg, id_branch, stall, flush,
    input  idex_valid, idex_pc, idex_rs1_data, idex_rs2_data, idex_imm,
           idex_rs1, idex_rs2, idex_rd, idex_aluop, idex_alusrc, idex_regwrite,
           idex_memread, idex_memwrite, idex_memtoreg, idex_branch,
           load_use_hazard, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite,
           id_memtoreg, id_branch, stall, flush,
    output idex_valid, idex_pc, idex_rs1_data, idex_rs2_data, idex_imm,
           idex_rs1, idex_rs2, idex_rd, idex_aluop, idex_alusrc, idex_regwrite,
           idex_memread, idex_memwrite, idex_memtoreg, idex_branch,
           load_use_hazard, bubble_count
  );
endinterface

// File: rtl/id_ex_register_lu_hazard_detect.sv
// Load-use comparator: a load sitting in ID/EX whose destination is read by
// the instruction currently in decode. Register x0 never hazards.
module lu_hazard_detect #(
  parameter int unsigned REG_AW = id_ex_register_pkg::REG_AW_DEF
) (
  input  logic              idex_valid_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              load_use_hazard_o
);
  // Pure combinational compare against the current ID/EX contents.
  always_comb begin
    load_use_hazard_o = idex_valid_i & idex_memread_i & (idex_rd_i != '0) &
                        id_valid_i & ((idex_rd_i == id_rs1_i) | (idex_rd_i == id_rs2_i));
  end
endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall, flush, automatic load-use bubble
// insertion and a saturating count of inserted bubbles.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEF,
  parameter int unsigned REG_AW         = REG_AW_DEF,
  parameter bit          AUTO_LU_BUBBLE = 1'b1,
  parameter int unsigned CNT_W          = 32
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_register_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        aluop;
    logic              alusrc;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              branch;
  } fields_t;

  fields_t          fields_q, fields_d, id_fields, bubble;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             count_bubble;
  logic             lu_hazard;

  lu_hazard_detect #(.REG_AW(REG_AW)) u_lu_hazard_detect (
    .idex_valid_i      (fields_q.valid),
    .idex_memread_i    (fields_q.memread),
    .idex_rd_i         (fields_q.rd),
    .id_valid_i        (bus.id_valid),
    .id_rs1_i          (bus.id_rs1),
    .id_rs2_i          (bus.id_rs2),
    .load_use_hazard_o (lu_hazard)
  );

  // Gather decode-side fields and build the bubble slot.
  always_comb begin
    id_fields          = '0;
    id_fields.valid    = bus.id_valid;
    id_fields.pc       = bus.id_pc;
    id_fields.rs1_data = bus.id_rs1_data;
    id_fields.rs2_data = bus.id_rs2_data;
    id_fields.imm      = bus.id_imm;
    id_fields.rs1      = bus.id_rs1;
    id_fields.rs2      = bus.id_rs2;
    id_fields.rd       = bus.id_rd;
    id_fields.aluop    = bus.id_aluop;
    id_fields.alusrc   = bus.id_alusrc;
    id_fields.regwrite = bus.id_regwrite;
    id_fields.memread  = bus.id_memread;
    id_fields.memwrite = bus.id_memwrite;
    id_fields.memtoreg = bus.id_memtoreg;
    id_fields.branch   = bus.id_branch;
    bubble             = '0;
    bubble.valid       = BUBBLE_VALID;
    bubble.aluop       = BUBBLE_ALUOP;
  end

  // Next-state selection: flush > stall > load-use bubble > capture.
  // An idle decode slot becomes a bubble but is not counted as inserted.
  always_comb begin
    fields_d     = fields_q;
    count_bubble = 1'b0;
    if (bus.flush) begin
      fields_d     = bubble;
      count_bubble = 1'b1;
    end else if (bus.stall) begin
      fields_d = fields_q;
    end else if (AUTO_LU_BUBBLE && lu_hazard) begin
      fields_d     = bubble;
      count_bubble = 1'b1;
    end else if (bus.id_valid) begin
      fields_d = id_fields;
    end else begin
      fields_d = bubble;
    end
    cnt_d = cnt_q;
    if (count_bubble && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline register and bubble counter, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fields_q <= '0;
      cnt_q    <= '0;
    end else begin
      fields_q <= fields_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.idex_valid      = fields_q.valid;
  assign bus.idex_pc         = fields_q.pc;
  assign bus.idex_rs1_data   = fields_q.rs1_data;
  assign bus.idex_rs2_data   = fields_q.rs2_data;
  assign bus.idex_imm        = fields_q.imm;
  assign bus.idex_rs1        = fields_q.rs1;
  assign bus.idex_rs2        = fields_q.rs2;
  assign bus.idex_rd         = fields_q.rd;
  assign bus.idex_aluop      = fields_q.aluop;
  assign bus.idex_alusrc     = fields_q.alusrc;
  assign bus.idex_regwrite   = fields_q.regwrite;
  assign bus.idex_memread    = fields_q.memread;
  assign bus.idex_memwrite   = fields_q.memwrite;
  assign bus.idex_memtoreg   = fields_q.memtoreg;
  assign bus.idex_branch     = fields_q.branch;
  assign bus.load_use_hazard = lu_hazard;
  assign bus.bubble_count    = cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed vector table, async reset, counter
// saturation on a narrow-counter instance, then randomized traffic against
// a behavioural model.
module tb_id_ex_register;
  import id_ex_register_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_register_if #(.XLEN(64), .REG_AW(5), .CNT_W(32)) bus ();
  id_ex_register_if #(.XLEN(64), .REG_AW(5), .CNT_W(4))  bus4 ();

  id_ex_register #(.XLEN(64), .REG_AW(5), .AUTO_LU_BUBBLE(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_register #(.XLEN(64), .REG_AW(5), .AUTO_LU_BUBBLE(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  aluop;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
  } fld_t;

  typedef struct {
    fld_t        in;
    logic        stall;
    logic        flush;
    logic        exp_hz;
    fld_t        exp_out;
    logic [31:0] exp_cnt;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic fld_t mk(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [3:0] op, input logic mr);
    fld_t f = '0;
    f.valid = v;  f.pc = pc;  f.rs1d = pc + 64'h11;  f.rs2d = ~pc;
    f.imm = {32'hFFFF_FFFF, pc[31:0]};
    f.rs1 = rs1;  f.rs2 = rs2;  f.rd = rd;  f.aluop = op;
    f.memread = mr;  f.memtoreg = mr;  f.alusrc = mr;  f.regwrite = 1'b1;
    return f;
  endfunction

  // Load-use rule stated directly from the pipeline contract.
  function automatic logic hz(input fld_t cur, input fld_t nxt);
    return cur.valid && cur.memread && (cur.rd != 0) && nxt.valid &&
           (cur.rd == nxt.rs1 || cur.rd == nxt.rs2);
  endfunction

  task automatic drive(input fld_t f, input logic st, input logic fl);
    bus.id_valid = f.valid;  bus.id_pc = f.pc;  bus.id_rs1_data = f.rs1d;
    bus.id_rs2_data = f.rs2d;  bus.id_imm = f.imm;  bus.id_rs1 = f.rs1;
    bus.id_rs2 = f.rs2;  bus.id_rd = f.rd;  bus.id_aluop = f.aluop;
    bus.id_alusrc = f.alusrc;  bus.id_regwrite = f.regwrite;
    bus.id_memread = f.memread;  bus.id_memwrite = f.memwrite;
    bus.id_memtoreg = f.memtoreg;  bus.id_branch = f.branch;
    bus.stall = st;  bus.flush = fl;
  endtask

  task automatic drive4(input logic fl);
    bus4.id_valid = 1'b0;  bus4.id_pc = '0;  bus4.id_rs1_data = '0;
    bus4.id_rs2_data = '0;  bus4.id_imm = '0;  bus4.id_rs1 = '0;
    bus4.id_rs2 = '0;  bus4.id_rd = '0;  bus4.id_aluop = '0;
    bus4.id_alusrc = 1'b0;  bus4.id_regwrite = 1'b0;  bus4.id_memread = 1'b0;
    bus4.id_memwrite = 1'b0;  bus4.id_memtoreg = 1'b0;  bus4.id_branch = 1'b0;
    bus4.stall = 1'b0;  bus4.flush = fl;
  endtask

  function automatic fld_t rd_dut();
    fld_t f;
    f.valid = bus.idex_valid;  f.pc = bus.idex_pc;  f.rs1d = bus.idex_rs1_data;
    f.rs2d = bus.idex_rs2_data;  f.imm = bus.idex_imm;  f.rs1 = bus.idex_rs1;
    f.rs2 = bus.idex_rs2;  f.rd = bus.idex_rd;  f.aluop = bus.idex_aluop;
    f.alusrc = bus.idex_alusrc;  f.regwrite = bus.idex_regwrite;
    f.memread = bus.idex_memread;  f.memwrite = bus.idex_memwrite;
    f.memtoreg = bus.idex_memtoreg;  f.branch = bus.idex_branch;
    return f;
  endfunction

  vec_t tbl[13];
  fld_t r0, r1, r2, r4, r5, r9, r10, r11, r12, mdl, f;
  int unsigned mcnt;
  logic st, fl, hzv;

  initial begin
    drive('0, 1'b0, 1'b0);
    drive4(1'b0);

    r0 = mk(1'b1, 64'h1000, 5'd1, 5'd2, 5'd7, ALU_SUB, 1'b0);
    r0.rs1d = 64'h5;  r0.imm = 64'hFFFF_FFFF_FFFF_FFFC;  r0.alusrc = 1'b1;
    r1  = mk(1'b1, 64'h1004, 5'd3, 5'd4, 5'd5, ALU_ADD, 1'b1);
    r2  = mk(1'b1, 64'h1008, 5'd6, 5'd5, 5'd8, ALU_AND, 1'b0);
    r4  = mk(1'b1, 64'h100C, 5'd0, 5'd0, 5'd0, ALU_ADD, 1'b1);
    r5  = mk(1'b1, 64'h1010, 5'd0, 5'd0, 5'd9, ALU_OR,  1'b0);
    r9  = mk(1'b0, 64'h3000, 5'd1, 5'd1, 5'd1, ALU_XOR, 1'b0);
    r10 = mk(1'b1, 64'h1014, 5'd1, 5'd2, 5'd3, ALU_ADD, 1'b1);
    r11 = mk(1'b1, 64'h1018, 5'd3, 5'd0, 5'd4, ALU_SUB, 1'b0);
    r12 = mk(1'b1, 64'h101C, 5'd3, 5'd0, 5'd4, ALU_SUB, 1'b0);

    tbl[0]  = '{r0,  1'b0, 1'b0, 1'b0, r0,  32'd0};
    tbl[1]  = '{r1,  1'b0, 1'b0, 1'b0, r1,  32'd0};
    tbl[2]  = '{r2,  1'b0, 1'b0, 1'b1, '0,  32'd1};
    tbl[3]  = '{r2,  1'b0, 1'b0, 1'b0, r2,  32'd1};
    tbl[4]  = '{r4,  1'b0, 1'b0, 1'b0, r4,  32'd1};
    tbl[5]  = '{r5,  1'b0, 1'b0, 1'b0, r5,  32'd1};
    for (int i = 0; i < 3; i++)
      tbl[6+i] = '{mk(1'b1, 64'h2000 + 64'(4*i), 5'd9, 5'd9, 5'd2, ALU_SLL, 1'b1),
                   1'b1, 1'b0, 1'b0, r5, 32'd1};
    tbl[9]  = '{r9,  1'b0, 1'b0, 1'b0, '0,  32'd1};
    tbl[10] = '{r10, 1'b0, 1'b0, 1'b0, r10, 32'd1};
    tbl[11] = '{r11, 1'b1, 1'b1, 1'b1, '0,  32'd2};
    tbl[12] = '{r12, 1'b0, 1'b0, 1'b0, r12, 32'd2};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_fields", 512'(rd_dut()), 512'(fld_t'('0)));
    chk("reset_count", 512'(bus.bubble_count), 512'(0));
    chk("reset_hazard", 512'(bus.load_use_hazard), 512'(0));
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].in, tbl[i].stall, tbl[i].flush);
      #1;
      chk($sformatf("tbl%0d_hazard", i), 512'(bus.load_use_hazard), 512'(tbl[i].exp_hz));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_fields", i), 512'(rd_dut()), 512'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_count", i), 512'(bus.bubble_count), 512'(tbl[i].exp_cnt));
    end

    // Asynchronous reset mid-cycle while valid data is held
    @(negedge clk);
    drive(r0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_fields", 512'(rd_dut()), 512'(fld_t'('0)));
    chk("async_rst_count", 512'(bus.bubble_count), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_capture", 512'(rd_dut()), 512'(r0));

    // Narrow counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive4(1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d", i), 512'(bus4.bubble_count), 512'((i + 1 > 15) ? 15 : i + 1));
    end
    @(negedge clk);
    drive4(1'b0);

    // Randomized traffic against the model
    mdl  = r0;
    mcnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      f = '0;
      f.valid = ($urandom_range(0, 3) != 0);
      f.pc = {$urandom, $urandom};  f.rs1d = {$urandom, $urandom};
      f.rs2d = {$urandom, $urandom};  f.imm = {$urandom, $urandom};
      f.rs1 = 5'($urandom_range(0, 3));  f.rs2 = 5'($urandom_range(0, 3));
      f.rd = 5'($urandom_range(0, 3));  f.aluop = 4'($urandom_range(0, 9));
      f.alusrc = 1'($urandom);  f.regwrite = 1'($urandom);
      f.memread = 1'($urandom);  f.memwrite = 1'($urandom);
      f.memtoreg = 1'($urandom);  f.branch = 1'($urandom);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 9) == 0);
      drive(f, st, fl);
      hzv = hz(mdl, f);
      #1;
      chk("rnd_hazard", 512'(bus.load_use_hazard), 512'(hzv));
      if (fl) begin
        mdl = '0;  mcnt++;
      end else if (st) begin
        mdl = mdl;
      end else if (hzv) begin
        mdl = '0;  mcnt++;
      end else begin
        mdl = f.valid ? f : fld_t'('0);
      end
      @(posedge clk);
      #1;
      chk("rnd_fields", 512'(rd_dut()), 512'(mdl));
      chk("rnd_count", 512'(bus.bubble_count), 512'(mcnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- Pipeline register between the decode stage and the execution stage of the 64-bit five-stage pipeline.
- Captures decoded operands, immediate, destination register and control bits (ALU op, alusrc, memory and writeback controls) each cycle; the execution stage and downstream stages consume them.
- Supports stall (hold), flush (bubble) and automatic load-use bubble insertion.
- Reports the load-use hazard to the front end and counts inserted bubbles.

Parameters:
XLEN, 64, datapath width of operands, immediate and PC
REG_AW, 5, register-address width
AUTO_LU_BUBBLE, 1, 1 = insert a bubble internally on a detected load-use hazard
CNT_W, 32, width of the saturating bubble counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage presents a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  register-file read 1
id_rs2_data  in  XLEN  register-file read 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  REG_AW  source 1 address
id_rs2  in  REG_AW  source 2 address
id_rd  in  REG_AW  destination address
id_aluop  in  4  ALU op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SRL, 0110 SLL, 0111 SRA, 1000 SLT, 1001 SLTU
id_alusrc  in  1  1 = ALU operand b is the immediate
id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch  in  1 each  control bits
stall  in  1  hold the current contents
flush  in  1  replace the contents with a bubble (branch taken)
idex_valid, idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, idex_rs1, idex_rs2, idex_rd, idex_aluop, idex_alusrc, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_branch  out  widths as the matching id_ input  registered fields
load_use_hazard  out  1  combinational hazard flag to the IF/ID stall logic
bubble_count  out  CNT_W  number of bubbles inserted

Behaviour:
- Reset: asynchronous on rst_n low. Every registered output, including bubble_count, is 0. This is a bubble with aluop 0000 (ADD).
- Bubble contents: valid, all control bits, rd, rs1, rs2, aluop, pc, the data fields and imm are all 0.
- Latency: one cycle. Fields presented on id_* before edge N appear on idex_* after edge N.
- load_use_hazard = idex_valid & idex_memread & (idex_rd != 0) & id_valid & (idex_rd == id_rs1 | idex_rd == id_rs2).
  - Purely combinational from the current idex_* registers and the id_* inputs.
  - Asserted regardless of AUTO_LU_BUBBLE.
- Per-edge priority:
  1. flush: load a bubble.
  2. stall: hold all fields unchanged; no bubble is counted.
  3. AUTO_LU_BUBBLE && load_use_hazard: load a bubble.
  4. Otherwise capture the id_* fields. If id_valid = 0, load a bubble instead; this is not counted.
- bubble_count increments by 1 on each edge where case 1 or case 3 loads a bubble. It saturates at 2^CNT_W-1 and never wraps.
- Flush and stall asserted together: flush wins; the bubble is loaded and counted.
- Flush while a load-use hazard is pending: a single bubble is loaded, counted once.
- Stall held for many cycles: contents stay bit-identical.
- load_use_hazard continues to evaluate against the held contents while stall is asserted.
- rd = 0 never raises a hazard.
- A reset pulse mid-operation clears everything immediately, without waiting for a clock edge. Capture resumes on the first edge after deassertion.

Decomposition:
- Shared package or include (alongside the ALU-op encoding used by the execution stage): ALU op localparams (ALU_ADD = 4'b0000 … ALU_SLTU = 4'b1001), REG_AW and XLEN defaults, and a bubble-value constant.
- One natural sub-module: lu_hazard_detect, the pure comparator producing load_use_hazard. The register and counter stay in the top.

Test Plan:
1. rst_n low mid-cycle while holding valid data → all outputs 0 immediately; bubble_count = 0.
2. Capture: id_valid = 1, pc = 0x1000, rs1_data = 0x5, imm = 0xFFFF_FFFF_FFFF_FFFC, aluop = 0001, alusrc = 1, rd = 7 → the same values appear on idex_* after one edge.
3. Load-use: idex holds memread = 1, rd = 5; id presents rs2 = 5 → load_use_hazard = 1; the next edge gives idex_valid = 0, regwrite = 0, bubble_count = 1. Repeat with rd = 0 → no hazard.
4. Stall for 3 cycles with changing id_* → idex_* unchanged for 3 cycles; bubble_count unchanged.
5. flush and stall together, with a load-use hazard present → one bubble; bubble_count increments by exactly 1.
6. Saturation: CNT_W = 4, 20 flushes → bubble_count stops at 15.
